// File: rtl/rv32i_sim_ctrl.sv
// rv32i_sim_ctrl: sequences core reset, counts run cycles/retires, detects tohost termination and timeout
module rv32i_sim_ctrl #(
  parameter int unsigned RESET_CYCLES   = 4,
  parameter int unsigned MAX_CYCLES     = 100000,
  parameter logic [31:0] TOHOST_ADDR    = 32'h0000_01FC,
  parameter int unsigned CNT_W          = 32,
  parameter bit          FREEZE_ON_DONE = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             core_rst_n,
  input  logic             mem_we,
  input  logic [31:0]      mem_addr,
  input  logic [31:0]      mem_wdata,
  input  logic             retire_valid,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [30:0]      exit_code,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] retire_count
);
  typedef enum logic [1:0] {RESET, RUN, DONE} state_t;
  localparam int RW = RESET_CYCLES > 1 ? $clog2(RESET_CYCLES) : 1;
  localparam logic [CNT_W-1:0] ONES = '1;
  state_t state;
  logic [RW-1:0] rst_cnt;
  logic term, tmo;
  assign term = mem_we && mem_addr == TOHOST_ADDR && mem_wdata[0];
  // compared at 64 bits so a limit beyond the counter range can never alias
  assign tmo = MAX_CYCLES != 0 && 64'(cycle_count) == 64'(MAX_CYCLES) - 64'd1;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= RESET;
      rst_cnt      <= '0;
      core_rst_n   <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      timeout      <= 1'b0;
      exit_code    <= '0;
      cycle_count  <= '0;
      retire_count <= '0;
    end else begin
      case (state)
        RESET: begin
          rst_cnt <= rst_cnt + 1'b1;
          if (rst_cnt == RW'(RESET_CYCLES - 1)) begin
            state      <= RUN;
            core_rst_n <= 1'b1;
          end
        end
        RUN: begin
          cycle_count <= cycle_count == ONES ? cycle_count : cycle_count + 1'b1;
          if (retire_valid && retire_count != ONES) retire_count <= retire_count + 1'b1;
          if (term) begin
            exit_code <= mem_wdata[31:1];
            pass      <= mem_wdata[31:1] == 31'd0;
            done      <= 1'b1;
            state     <= DONE;
          end else if (tmo) begin
            timeout <= 1'b1;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: core_rst_n <= !FREEZE_ON_DONE;
        default: state <= RESET;
      endcase
    end
  end
endmodule

// File: tb/tb_rv32i_sim_ctrl.sv
// tb_rv32i_sim_ctrl: two configurations driven with shared stimulus, checked against a closed-form run model
module tb_rv32i_sim_ctrl;
  localparam logic [31:0] TOHOST = 32'h0000_01FC;
  localparam int TMAX = 160;
  logic clk = 1'b0, rst_n = 1'b0, mem_we = 1'b0, retire_valid = 1'b0;
  logic [31:0] mem_addr = '0, mem_wdata = '0;
  logic a_core_rst_n, a_done, a_pass, a_timeout;
  logic [30:0] a_exit_code;
  logic [31:0] a_cycle_count, a_retire_count;
  logic b_core_rst_n, b_done, b_pass, b_timeout;
  logic [30:0] b_exit_code;
  logic [3:0] b_cycle_count, b_retire_count;
  logic s_we [TMAX];
  logic s_rv [TMAX];
  logic [31:0] s_addr [TMAX];
  logic [31:0] s_wd [TMAX];
  int vectors = 0, errors = 0;
  always #5 clk = ~clk;
  rv32i_sim_ctrl #(.RESET_CYCLES(4), .MAX_CYCLES(60), .TOHOST_ADDR(TOHOST), .CNT_W(32), .FREEZE_ON_DONE(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .core_rst_n(a_core_rst_n), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .retire_valid(retire_valid), .done(a_done), .pass(a_pass),
    .timeout(a_timeout), .exit_code(a_exit_code), .cycle_count(a_cycle_count), .retire_count(a_retire_count));
  rv32i_sim_ctrl #(.RESET_CYCLES(1), .MAX_CYCLES(0), .TOHOST_ADDR(TOHOST), .CNT_W(4), .FREEZE_ON_DONE(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .core_rst_n(b_core_rst_n), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .retire_valid(retire_valid), .done(b_done), .pass(b_pass),
    .timeout(b_timeout), .exit_code(b_exit_code), .cycle_count(b_cycle_count), .retire_count(b_retire_count));
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // expected outputs after the t-th edge since reset release, from the whole stimulus history
  function automatic logic [127:0] model(input int rc, input longint maxc, input int w, input bit frz, input int t);
    longint maxcnt, n, e, last, ret, cyc;
    logic [30:0] ec;
    bit core, dn, ps, to;
    maxcnt = (longint'(1) << w) - 1;
    e = -1; ret = 0; ec = '0; dn = 0; ps = 0; to = 0; core = 1;
    if (t < rc - 1) return '0;
    n = t - rc + 1;
    for (longint j = 0; j < n; j++) begin
      if ((s_we[rc+j] && s_addr[rc+j] == TOHOST && s_wd[rc+j][0]) ||
          (maxc != 0 && (j < maxcnt ? j : maxcnt) == maxc - 1)) begin
        e = j;
        break;
      end
    end
    last = e < 0 ? n : e + 1;
    for (longint j = 0; j < last; j++) ret += longint'(s_rv[rc+j]);
    if (ret > maxcnt) ret = maxcnt;
    cyc = last < maxcnt ? last : maxcnt;
    if (e >= 0) begin
      dn = 1;
      if (s_we[rc+e] && s_addr[rc+e] == TOHOST && s_wd[rc+e][0]) begin
        ec = s_wd[rc+e][31:1];
        ps = ec == 0;
      end else to = 1;
      core = !(frz && n > e + 1);
    end
    return {29'b0, core, dn, ps, to, ec, 32'(cyc), 32'(ret)};
  endfunction
  function automatic logic [127:0] obs_a();
    return {29'b0, a_core_rst_n, a_done, a_pass, a_timeout, a_exit_code, a_cycle_count, a_retire_count};
  endfunction
  function automatic logic [127:0] obs_b();
    return {29'b0, b_core_rst_n, b_done, b_pass, b_timeout, b_exit_code, 28'b0, b_cycle_count, 28'b0, b_retire_count};
  endfunction
  task automatic fill_idle();
    for (int i = 0; i < TMAX; i++) begin
      s_we[i]   = 1'($urandom_range(0, 1));
      s_addr[i] = TOHOST + 32'(4 * $urandom_range(1, 8));
      s_wd[i]   = $urandom;
      s_rv[i]   = 1'($urandom_range(0, 1));
    end
  endtask
  task automatic put(input int t, input logic [31:0] addr, input logic [31:0] wd);
    s_we[t] = 1'b1; s_addr[t] = addr; s_wd[t] = wd;
  endtask
  task automatic drive(input int t);
    mem_we = s_we[t]; mem_addr = s_addr[t]; mem_wdata = s_wd[t]; retire_valid = s_rv[t];
  endtask
  task automatic run(input string name, input int len);
    rst_n = 1'b0; mem_we = 1'b1; mem_addr = TOHOST; mem_wdata = 32'h1; retire_valid = 1'b1;
    repeat (2) begin
      @(posedge clk); @(negedge clk);
      chk({name, "/rst_a"}, obs_a(), '0);
      chk({name, "/rst_b"}, obs_b(), '0);
    end
    rst_n = 1'b1;
    drive(0);
    for (int t = 0; t < len; t++) begin
      @(posedge clk); @(negedge clk);
      chk($sformatf("%s/a@%0d", name, t), obs_a(), model(4, 60, 32, 1'b1, t));
      chk($sformatf("%s/b@%0d", name, t), obs_b(), model(1, 0, 4, 1'b0, t));
      if (t + 1 < len) drive(t + 1);
    end
  endtask
  initial begin
    fill_idle();
    for (int i = 0; i < TMAX; i++) s_rv[i] = (i % 2) == 0;
    put(54, TOHOST, 32'h1);
    run("pass", 64);
    fill_idle();
    put(7, TOHOST, 32'h6);
    put(9, TOHOST + 32'd4, 32'h1);
    put(14, TOHOST, 32'h7);
    run("fail", 30);
    fill_idle();
    run("timeout", 70);
    fill_idle();
    put(63, TOHOST, 32'h1);
    run("store_on_last", 70);
    for (int k = 0; k < 8; k++) begin
      fill_idle();
      for (int i = 0; i < TMAX; i++)
        if ($urandom_range(0, 19) == 0) put(i, TOHOST, $urandom);
      run($sformatf("rand%0d", k), $urandom_range(10, 150));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
